seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative shift-add multiplier for the M-extension datapath of the single-cycle core.
- Sits directly downstream of the adder: each iteration feeds a partial-product add and consumes the sum and carry.
- Used as a stall-capable side unit. The core holds the PC while busy is high and writes product back when done pulses.
- One clock domain; one add per cycle.

Parameters:
- WIDTH, 32, operand width in bits. product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while iterating (state RUN)
- done  output  1  one-cycle pulse; product is valid
- product  output  2*WIDTH  result; holds until the next result is written or reset

Behaviour:
- Reset: one clock, asynchronous and active-low. rst_n low forces state=IDLE, busy=0, done=0, product=0, and clears all internal registers. Reset mid-operation aborts the operation; no partial result is ever visible.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- IDLE, start=1 at edge E0:
  - Latch sign_neg = op_signed & (a[MSB] ^ b[MSB]).
  - Latch mcand = |a| and mplier = |b|. Magnitudes apply only when op_signed=1; otherwise raw values.
  - Clear the 2*WIDTH accumulator and the iteration counter. Go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - If mplier[0]=1, add mcand shifted left by the counter into the accumulator. Full 2*WIDTH-bit add; the carry is kept, never truncated.
  - Shift mplier right 1; counter+1.
  - On the edge where counter==WIDTH-1: write product = sign_neg ? -acc_next : acc_next, then go to DONE.
- Latency: the product write happens at edge E_WIDTH. done is high for exactly the one cycle between E_WIDTH and E_WIDTH+1; busy is low in that cycle.
- DONE: unconditionally return to IDLE on the next edge. start in DONE is ignored. Earliest back-to-back start is sampled at E_WIDTH+2.
- start while RUN or DONE is ignored. Operands and op_signed may change freely after E0.
- Magnitude of the most-negative value (0x80..0) is 2^(WIDTH-1) as an unsigned WIDTH-bit value; the result must be correct.
- Result is the exact 2*WIDTH-bit product; overflow is impossible.
- a=0 or b=0 still runs full latency (default build) and yields 0. The sign fix of -0 is 0.
- product holds its last value through IDLE/RUN until the next DONE write.

Optional Feature:
- Macro: SEQ_MUL_EARLY_TERM_EN.
- Defined: in RUN, if the shifted mplier is zero after the current iteration, write product and go to DONE on that edge.
  - Iteration count = index of the highest set bit of |b| + 1, minimum 1 (b=0 takes 1 iteration).
  - done timing shifts accordingly; all other rules are unchanged.
- Undefined: fixed WIDTH iterations, as specified above.

Test Plan:
- Unsigned basic, WIDTH=32: unsigned a=7, b=6, start at E0 → busy=1 for 32 cycles; done=1 exactly after E32; product=0x000000000000002A; busy=0 and done=0 after E33.
- Signed mixed: signed a=0xFFFFFFFD (-3), b=5 → product=0xFFFFFFFFFFFFFFF1. Then signed a=-3, b=-5 → 0x000000000000000F.
- Extremes:
  - Unsigned a=b=0xFFFFFFFF → 0xFFFFFFFE00000001.
  - Signed a=b=0x80000000 → 0x4000000000000000.
  - Signed a=0x80000000, b=1 → 0xFFFFFFFF80000000.
- Ignored start: unsigned 3×4 running; pulse start with a=9, b=9 at cycles 5 and 32 (DONE) → result 12, single done pulse. A new start at E34 is accepted.
- Reset mid-operation: drop rst_n at cycle 10 of a run, asynchronously mid-cycle → busy, done and product go to 0 immediately. After release, no done pulse until a new start.
- With SEQ_MUL_EARLY_TERM_EN: unsigned a=5, b=3 → done after E2, product=15. With b=0 → done after E1, product=0.

Source files
------------

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, one partial-product add per cycle
// Optional early termination when the remaining multiplier bits are zero: SEQ_MUL_EARLY_TERM_EN
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, acc_next, addend;
  logic [CW-1:0]      cnt;
  logic               sign_neg;
  logic               last;

  always_comb begin
    a_mag  = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (op_signed && b[WIDTH-1]) ? -b : b;
    addend = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    acc_next = acc + addend;
`ifdef SEQ_MUL_EARLY_TERM_EN
    last = (cnt == CW'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    last = (cnt == CW'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operate on magnitudes; the sign is reapplied once on the final sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign_neg <= 1'b0;
      product  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sign_neg <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          mcand    <= a_mag;
          mplier   <= b_mag;
          acc      <= '0;
          cnt      <= '0;
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) product <= sign_neg ? -acc_next : acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier with an arithmetic reference model
module tb_seq_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           op_signed = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;
  exp_t exp_q[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_signed(op_signed),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] model_prod(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(sx * sy);
  endfunction

  function automatic int model_lat(input logic s, input logic [W-1:0] y);
`ifdef SEQ_MUL_EARLY_TERM_EN
    longint m;
    int n;
    m = s ? longint'($signed(y)) : longint'({32'b0, y});
    if (m < 0) m = -m;
    n = 1;
    for (int i = 0; i < W; i++) if ((m >> i) & 1) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) check("busy_and_done", 64'(busy & done), 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("product", product, e.prod);
          check("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 200);
    if (!done) check("done_timeout", 64'(k), 64'd0);
  endtask

  task automatic push_start(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op_signed = s; a = x; b = y;
    e.prod = model_prod(s, x, y);
    e.cyc  = cyc + 1 + model_lat(s, y);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op_signed = $urandom_range(0, 1); a = $urandom; b = $urandom;
  endtask

  task automatic run(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    push_start(s, x, y);
    wait_done();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    rst_n = 1'b1;

    run(1'b0, 32'd7, 32'd6);
    run(1'b1, 32'hFFFFFFFD, 32'd5);
    run(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB);
    run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(1'b1, 32'h80000000, 32'h80000000);
    run(1'b1, 32'h80000000, 32'd1);
    run(1'b0, 32'd5, 32'd3);
    run(1'b0, 32'd0, 32'd12345);
    run(1'b0, 32'd77, 32'd0);
    run(1'b1, 32'd0, 32'hFFFFFFFF);

    // Starts during RUN and during the done cycle must be ignored.
    push_start(1'b0, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    wait_done();
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (40) @(posedge clk);
    run(1'b0, 32'd10, 32'd11);

    // Asynchronous reset mid-run aborts with no visible result.
    push_start(1'b0, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    exp_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_product", product, 64'd0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = (i % 5 == 0) ? (32'($urandom) >> $urandom_range(0, 31)) : 32'($urandom);
      run(1'($urandom_range(0, 1)), x, y);
    end

    repeat (5) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
